// File: rtl/sha3_absorb_ctrl.sv
`default_nettype none
// sha3_absorb_ctrl: SHA-3/SHAKE sponge absorb and pad10*1 padding controller.
// Lanes are XORed into the rate portion; Keccak-f is external (perm_start/perm_done).
module sha3_absorb_ctrl #(
  parameter int         LANE_W   = 64,
  parameter int         STATE_W  = 1600,
  parameter logic [7:0] DS_SHA3  = 8'h06,
  parameter logic [7:0] DS_SHAKE = 8'h1F
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANE_W-1:0]  in_data,
  input  logic [3:0]         in_bytes,
  input  logic               in_last,
  output logic               perm_start,
  input  logic               perm_done,
  input  logic [STATE_W-1:0] perm_state_in,
  output logic [STATE_W-1:0] state_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABSORB = 3'd1,
    PERM   = 3'd2,
    PAD    = 3'd3,
    FINAL  = 3'd4
  } state_e;

  state_e             fsm_q;
  logic [STATE_W-1:0] state_q;
  logic [4:0]         lane_idx_q;
  logic [1:0]         mode_q;
  logic               pad_pend_q;
  logic               perm_start_q;
  logic               done_q;

  logic [4:0]         rate_m1;
  logic [7:0]         ds_byte;
  logic               full_last;
  logic               lane_is_end;
  logic [10:0]        lane_base;
  logic [10:0]        pad_base;
  logic [LANE_W-1:0]  lane_masked;
  logic [STATE_W-1:0] absorb_x;
  logic [STATE_W-1:0] pad_x;

  always_comb begin
    case (mode_q)
      2'd0:    rate_m1 = 5'd16;
      2'd1:    rate_m1 = 5'd8;
      2'd2:    rate_m1 = 5'd20;
      default: rate_m1 = 5'd16;
    endcase
  end

  assign ds_byte     = mode_q[1] ? DS_SHAKE : DS_SHA3;
  // in_bytes values of 8 and above all mean a completely filled final lane
  assign full_last   = in_bytes[3];
  assign lane_is_end = (lane_idx_q == rate_m1);
  assign lane_base   = {lane_idx_q, 6'd0};
  assign pad_base    = {rate_m1, 6'd0} + 11'd56;

  always_comb begin
    lane_masked = in_data;
    for (int b = 0; b < 8; b++) begin
      if (in_last && !full_last && (in_bytes[2:0] <= 3'(b)))
        lane_masked[8*b +: 8] = 8'h00;
    end
  end

  always_comb begin
    absorb_x = '0;
    absorb_x[lane_base +: LANE_W] = lane_masked;
    if (in_last && !full_last) begin
      absorb_x[lane_base + {5'd0, in_bytes[2:0], 3'd0} +: 8] ^= ds_byte;
      absorb_x[pad_base +: 8] ^= 8'h80;
    end
  end

  always_comb begin
    pad_x = '0;
    pad_x[lane_base +: 8] = ds_byte;
    pad_x[pad_base +: 8] ^= 8'h80;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= IDLE;
      state_q      <= '0;
      lane_idx_q   <= '0;
      mode_q       <= '0;
      pad_pend_q   <= 1'b0;
      perm_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      perm_start_q <= 1'b0;
      done_q       <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q    <= '0;
            mode_q     <= mode;
            lane_idx_q <= '0;
            pad_pend_q <= 1'b0;
            fsm_q      <= ABSORB;
          end
        end
        ABSORB: begin
          if (in_valid) begin
            state_q <= state_q ^ absorb_x;
            if (in_last && !full_last) begin
              fsm_q        <= FINAL;
              perm_start_q <= 1'b1;
            end else if (lane_is_end) begin
              // a full last lane that ends the block needs an extra padding block
              fsm_q        <= PERM;
              perm_start_q <= 1'b1;
              pad_pend_q   <= in_last;
            end else begin
              lane_idx_q <= lane_idx_q + 5'd1;
              if (in_last)
                fsm_q <= PAD;
            end
          end
        end
        PERM: begin
          if (perm_done) begin
            state_q    <= perm_state_in;
            lane_idx_q <= '0;
            pad_pend_q <= 1'b0;
            fsm_q      <= pad_pend_q ? PAD : ABSORB;
          end
        end
        PAD: begin
          state_q      <= state_q ^ pad_x;
          fsm_q        <= FINAL;
          perm_start_q <= 1'b1;
        end
        FINAL: begin
          if (perm_done) begin
            state_q <= perm_state_in;
            done_q  <= 1'b1;
            fsm_q   <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (fsm_q == ABSORB);
  assign busy       = (fsm_q != IDLE);
  assign perm_start = perm_start_q;
  assign done       = done_q;
  assign state_out  = state_q;

endmodule
`default_nettype wire
